// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared decode constants: producer latencies, register index
//               width, ALU opcodes and immediate formats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int RW       = 5;
    localparam int LAT_W    = 3;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_VAR  = 0;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    // M-extension ops on OP_ALU_R (funct7=1) are variable latency.
    function automatic logic [LAT_W-1:0] lat_for_op(input logic [6:0] opcode,
                                                    input logic [6:0] funct7);
        logic [LAT_W-1:0] lat;
        lat = LAT_W'(LAT_ALU);
        if (opcode == OP_LOAD)
            lat = LAT_W'(LAT_LOAD);
        else if (opcode == OP_ALU_R && funct7 == 7'b0000001)
            lat = LAT_W'(LAT_VAR);
        return lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_entry.sv
// ============================================================================
// Module      : sb_entry
// Description : One scoreboard slot: latency countdown plus variable-latency
//               pending flag, with issue-set priority over decrement/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_entry #(
    parameter int LAT_W    = 3,
    parameter int FWD_DIST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  logic [LAT_W-1:0] i_set_lat,
    input  logic             i_cpl,
    input  logic             i_flush,
    output logic [LAT_W-1:0] o_cnt,
    output logic             o_var,
    output logic             o_busy
);

    localparam logic [LAT_W-1:0] c_fwd = LAT_W'(FWD_DIST);

    logic [LAT_W-1:0] r_cnt;
    logic             r_var;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_var <= 1'b0;
        end else if (i_set) begin
            if (i_set_lat != '0) begin
                r_cnt <= i_set_lat;
            end else begin
                r_cnt <= '0;
                r_var <= 1'b1;
            end
        end else begin
            // Near-complete producers are older than the redirect and survive.
            if (i_flush && r_cnt > c_fwd)
                r_cnt <= '0;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (i_cpl)
                r_var <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_var  = r_var;
    assign o_busy = (r_cnt != '0) | r_var;

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register write scoreboard beside ID: RAW/WAW stall and
//               forward-eligibility for fixed and variable latency producers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int NREG     = 32,
    parameter int RW       = 5,
    parameter int LAT_W    = 3,
    parameter int FWD_DIST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [RW-1:0]    issue_rd,
    input  logic             issue_rd_we,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [RW-1:0]    rs1,
    input  logic [RW-1:0]    rs2,
    input  logic             rs1use,
    input  logic             rs2use,
    input  logic             cpl_valid,
    input  logic [RW-1:0]    cpl_rd,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic             rs1_fwd,
    output logic             rs2_fwd,
    output logic [NREG-1:0]  busy_vec
);

    import ctrl_pkg::*;

    localparam logic [LAT_W-1:0] c_fwd     = LAT_W'(FWD_DIST);
    localparam logic [LAT_W-1:0] c_lat_var = LAT_W'(LAT_VAR);

    logic [LAT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_var;
    logic             w_rs1_chk, w_rs2_chk;
    logic             w_rs1_hard, w_rs2_hard;
    logic             w_rd_chk, w_waw;

    assign w_cnt[0]    = '0;
    assign w_var[0]    = 1'b0;
    assign busy_vec[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_entry
            sb_entry #(
                .LAT_W    (LAT_W),
                .FWD_DIST (FWD_DIST)
            ) u_entry (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_set     (issue_fire & issue_rd_we & (issue_rd == RW'(r))),
                .i_set_lat (issue_lat),
                .i_cpl     (cpl_valid & (cpl_rd == RW'(r))),
                .i_flush   (flush),
                .o_cnt     (w_cnt[r]),
                .o_var     (w_var[r]),
                .o_busy    (busy_vec[r])
            );
        end
    endgenerate

    assign w_rs1_chk  = rs1use & (rs1 != '0);
    assign w_rs2_chk  = rs2use & (rs2 != '0);
    assign w_rs1_hard = w_rs1_chk & (w_var[rs1] | (w_cnt[rs1] > c_fwd));
    assign w_rs2_hard = w_rs2_chk & (w_var[rs2] | (w_cnt[rs2] > c_fwd));
    assign rs1_fwd    = w_rs1_chk & busy_vec[rs1] & ~w_rs1_hard;
    assign rs2_fwd    = w_rs2_chk & busy_vec[rs2] & ~w_rs2_hard;

    // A new write may not retire before (or with) an older one to the same rd.
    assign w_rd_chk = issue_rd_we & (issue_rd != '0);
    assign w_waw    = w_rd_chk & (w_var[issue_rd]
                    | ((issue_lat != c_lat_var) & (w_cnt[issue_rd] >= issue_lat))
                    | ((issue_lat == c_lat_var) & (w_cnt[issue_rd] != '0)));

    assign stall      = issue_valid & (w_rs1_hard | w_rs2_hard | w_waw);
    assign issue_fire = issue_valid & ~stall & ~flush;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic [2:0]  issue_lat;
    logic [4:0]  rs1, rs2;
    logic        rs1use, rs2use;
    logic        cpl_valid;
    logic [4:0]  cpl_rd;
    logic        flush;
    logic        stall, issue_fire, rs1_fwd, rs2_fwd;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(
        .NREG(32), .RW(5), .LAT_W(3), .FWD_DIST(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_lat(issue_lat), .rs1(rs1), .rs2(rs2), .rs1use(rs1use), .rs2use(rs2use),
        .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rd_we = 0; issue_lat = 0;
        rs1 = 0; rs2 = 0; rs1use = 0; rs2use = 0;
        cpl_valid = 0; cpl_rd = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat,
                         input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2);
        issue_valid = 1; issue_rd = rd; issue_rd_we = 1; issue_lat = lat;
        rs1 = s1; rs1use = u1; rs2 = s2; rs2use = u2;
        #1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0;
        #12;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp %h", busy_vec, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        rst_n = 1;
        step(); step();
    endtask

    task automatic test_alu_dep();
        issue(5'd3, 3'd1, 5'd0, 0, 5'd0, 0);
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL alu_fire: got %b exp 1", issue_fire); end
        step();
        checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL alu_busy3: got %h exp %h", busy_vec, 32'h8); end
        issue(5'd4, 3'd1, 5'd3, 1, 5'd0, 0);
        checks++; if ({stall, rs1_fwd, issue_fire} !== 3'b011) begin errors++; $display("FAIL alu_dep: got stall/fwd/fire %b exp 011", {stall, rs1_fwd, issue_fire}); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h10) begin errors++; $display("FAIL alu_clear3: got %h exp %h", busy_vec, 32'h10); end
        step();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL alu_idle: got %h exp 0", busy_vec); end
    endtask

    task automatic test_load_use();
        issue(5'd7, 3'd2, 5'd0, 0, 5'd0, 0);
        step();
        issue(5'd8, 3'd1, 5'd7, 1, 5'd1, 1);
        checks++; if ({stall, issue_fire} !== 2'b10) begin errors++; $display("FAIL lu_stall: got stall/fire %b exp 10", {stall, issue_fire}); end
        step();
        checks++; if ({stall, rs1_fwd, rs2_fwd, issue_fire} !== 4'b0101) begin errors++; $display("FAIL lu_fwd: got stall/f1/f2/fire %b exp 0101", {stall, rs1_fwd, rs2_fwd, issue_fire}); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h100) begin errors++; $display("FAIL lu_busy: got %h exp %h", busy_vec, 32'h100); end
        step();
    endtask

    task automatic test_var_latency();
        issue(5'd9, 3'd0, 5'd0, 0, 5'd0, 0);
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL var_fire: got %b exp 1", issue_fire); end
        step();
        issue(5'd10, 3'd1, 5'd9, 1, 5'd0, 0);
        checks++; if ({busy_vec[9], stall, rs1_fwd} !== 3'b110) begin errors++; $display("FAIL var_stall: got busy/stall/fwd %b exp 110", {busy_vec[9], stall, rs1_fwd}); end
        step(); step();
        cpl_valid = 1; cpl_rd = 5'd9; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL var_hold: got %b exp 1", stall); end
        step(); cpl_valid = 0; #1;
        checks++; if ({stall, rs1_fwd, issue_fire, busy_vec[9]} !== 4'b0010) begin errors++; $display("FAIL var_done: got stall/fwd/fire/busy %b exp 0010", {stall, rs1_fwd, issue_fire, busy_vec[9]}); end
        step(); idle(); step();
    endtask

    task automatic test_waw_x0();
        issue(5'd9, 3'd5, 5'd0, 0, 5'd0, 0);
        step();
        issue(5'd9, 3'd1, 5'd0, 0, 5'd0, 0);
        checks++; if ({stall, issue_fire} !== 2'b10) begin errors++; $display("FAIL waw_stall: got stall/fire %b exp 10", {stall, issue_fire}); end
        issue(5'd9, 3'd6, 5'd0, 0, 5'd0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_longer: got %b exp 0", stall); end
        issue(5'd9, 3'd0, 5'd0, 0, 5'd0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_var: got %b exp 1", stall); end
        issue(5'd0, 3'd1, 5'd0, 1, 5'd0, 1);
        checks++; if ({stall, rs1_fwd, issue_fire} !== 3'b001) begin errors++; $display("FAIL x0_issue: got stall/fwd/fire %b exp 001", {stall, rs1_fwd, issue_fire}); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL x0_busy: got %h exp %h", busy_vec, 32'h200); end
        repeat (4) step();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL waw_drain: got %h exp 0", busy_vec); end
    endtask

    task automatic test_flush();
        issue(5'd13, 3'd0, 5'd0, 0, 5'd0, 0); step();
        issue(5'd11, 3'd2, 5'd0, 0, 5'd0, 0); step();
        issue(5'd10, 3'd3, 5'd0, 0, 5'd0, 0); step();
        issue(5'd12, 3'd1, 5'd0, 0, 5'd0, 0);
        flush = 1; #1;
        checks++; if ({stall, issue_fire} !== 2'b00) begin errors++; $display("FAIL flush_fire: got stall/fire %b exp 00", {stall, issue_fire}); end
        checks++; if (busy_vec !== 32'h2C00) begin errors++; $display("FAIL flush_pre: got %h exp %h", busy_vec, 32'h2C00); end
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h2000) begin errors++; $display("FAIL flush_post: got %h exp %h", busy_vec, 32'h2000); end
        cpl_valid = 1; cpl_rd = 5'd13;
        step(); idle(); #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush_cpl: got %h exp 0", busy_vec); end
    endtask

    task automatic test_reset_midrun();
        issue(5'd5, 3'd2, 5'd0, 0, 5'd0, 0); step();
        issue(5'd6, 3'd0, 5'd0, 0, 5'd0, 0); step();
        idle(); #1;
        checks++; if (busy_vec !== 32'h60) begin errors++; $display("FAIL mid_pre: got %h exp %h", busy_vec, 32'h60); end
        rst_n = 0; #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL mid_async: got %h exp 0", busy_vec); end
        #1 rst_n = 1;
        step();
        issue(5'd2, 3'd1, 5'd6, 1, 5'd5, 1);
        checks++; if ({stall, rs1_fwd, rs2_fwd} !== 3'b000) begin errors++; $display("FAIL mid_release: got stall/f1/f2 %b exp 000", {stall, rs1_fwd, rs2_fwd}); end
        step(); idle(); step();
    endtask

    initial begin
        test_reset();
        test_alu_dep();
        test_load_use();
        test_var_latency();
        test_waw_x0();
        test_flush();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
